// File: rtl/bus_control_sequencer.sv
// bus_control_sequencer: T-state fetch/execute sequencer that drives the 15-bit bus control word.
// Define COND_JUMP_EN to enable JC (7) and JZ (8). Without it, those opcodes decode as NOP.
module bus_control_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output logic [14:0]         control_signals,
    output logic [STEP_W-1:0]   step,
    output logic                instr_done,
    output logic                halted
);
    localparam logic [14:0] HLT = 15'h0001, MI = 15'h0002, RI = 15'h0004, RO = 15'h0008;
    localparam logic [14:0] IO  = 15'h0010, II = 15'h0020, AI = 15'h0040, AO = 15'h0080;
    localparam logic [14:0] EO  = 15'h0100, SU = 15'h0200, BI = 15'h0400, OI = 15'h0800;
    localparam logic [14:0] CE  = 15'h1000, CO = 15'h2000, J  = 15'h4000;

    typedef enum logic [STEP_W-1:0] {T0, T1, T2, T3, T4} state_e;

    state_e            state, state_next;
    logic              halted_next;
    logic [14:0]       exec_word;
    logic [STEP_W-1:0] exec_len;
    logic              jc_take, jz_take;

`ifdef COND_JUMP_EN
    assign jc_take = carry_flag;
    assign jz_take = zero_flag;
`else
    logic unused_flags;
    assign unused_flags = carry_flag ^ zero_flag;
    assign jc_take      = 1'b0;
    assign jz_take      = 1'b0;
`endif

    // Each row names exactly one bus driver per step, which keeps the bus exclusive.
    always_comb begin
        exec_word = '0;
        exec_len  = STEP_W'(3);
        case (opcode)
            4'h1: begin
                exec_word = (state == T2) ? IO | MI : RO | AI;
                exec_len  = STEP_W'(4);
            end
            4'h2, 4'h3: begin
                exec_word = (state == T2) ? IO | MI :
                            (state == T3) ? RO | BI : EO | AI | (opcode[0] ? SU : '0);
                exec_len  = STEP_W'(5);
            end
            4'h4: begin
                exec_word = (state == T2) ? IO | MI : AO | RI;
                exec_len  = STEP_W'(4);
            end
            4'h5:    exec_word = IO | AI;
            4'h6:    exec_word = IO | J;
            4'h7:    exec_word = jc_take ? IO | J : '0;
            4'h8:    exec_word = jz_take ? IO | J : '0;
            4'hE:    exec_word = AO | OI;
            4'hF:    exec_word = HLT;
            default: exec_word = '0;
        endcase
    end

    // Fetch steps ignore opcode entirely, so an unsettled IR cannot leak onto the bus.
    always_comb begin
        state_next      = state;
        halted_next     = halted;
        control_signals = CO | MI;
        instr_done      = 1'b0;
        if (halted)
            control_signals = HLT;
        else if (state == T1)
            control_signals = RO | II | CE;
        else if (state != T0) begin
            control_signals = exec_word;
            instr_done      = state == state_e'(exec_len - 1'b1);
        end
        if (!halted) begin
            halted_next = (state == T2) && (opcode == 4'hF);
            state_next  = halted_next ? T2 : instr_done ? T0 : state_e'(state + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= T0;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= halted_next;
        end
    end

    assign step = state;
endmodule
